// File: rtl/branch_predict_if.sv
// Branch predictor bus: fetch-side lookup, decode-side resolution, redirect and statistics.
//   pred_idx       fetch index (PC[IDX_W+1:2])       pred_taken     prediction for pred_idx
//   res_valid      resolution strobe                 res_idx        index of resolved branch
//   res_type       branch type (BEQ..BLTZ)           res_flags      {ltz,lez,gtz,gez,eq}
//   res_pred       prediction fetch used             redirect       one-cycle mispredict pulse
//   redirect_taken refetch at target when 1          br_cnt/mp_cnt  branch / mispredict counts
// master = pipeline side driving fetch/resolve, slave = predictor.
interface branch_predict_if #(
    parameter int unsigned IDX_W = 6
);
    logic [IDX_W-1:0] pred_idx;
    logic             pred_taken;
    logic             res_valid;
    logic [IDX_W-1:0] res_idx;
    logic [2:0]       res_type;
    logic [4:0]       res_flags;
    logic             res_pred;
    logic             redirect;
    logic             redirect_taken;
    logic [31:0]      br_cnt;
    logic [31:0]      mp_cnt;

    modport master (
        output pred_idx, res_valid, res_idx, res_type, res_flags, res_pred,
        input  pred_taken, redirect, redirect_taken, br_cnt, mp_cnt
    );

    modport slave (
        input  pred_idx, res_valid, res_idx, res_type, res_flags, res_pred,
        output pred_taken, redirect, redirect_taken, br_cnt, mp_cnt
    );
endinterface

// File: rtl/branch_predict.sv
// Bimodal branch predictor: 2^IDX_W two-bit saturating counters indexed by PC bits.
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset (counters -> weak-not-taken 01)
//   bp   branch_predict_if.slave: lookup, resolution, redirect pulse, statistics
// Optional feature: define BP_STATS_EN to build the 32-bit branch/mispredict counters;
// otherwise br_cnt and mp_cnt are tied to zero.
module branch_predict #(
    parameter int unsigned IDX_W = 6
) (
    input logic            clk,
    input logic            rst,
    branch_predict_if.slave bp
);
    localparam int unsigned ENTRIES = 2 ** IDX_W;

    logic [1:0] tbl_q [ENTRIES];
    logic       redirect_q;
    logic       redirect_taken_q;

    logic       outcome;
    logic       type_ok;
    logic       res_ok;
    logic       mispredict;
    logic [1:0] ctr_cur;
    logic [1:0] ctr_nxt;

    // Decode branch outcome from comparator flags {ltz,lez,gtz,gez,eq}.
    always_comb begin
        outcome = 1'b0;
        type_ok = 1'b1;
        case (bp.res_type)
            3'b000:  outcome = bp.res_flags[0];
            3'b001:  outcome = ~bp.res_flags[0];
            3'b010:  outcome = bp.res_flags[1];
            3'b011:  outcome = bp.res_flags[2];
            3'b100:  outcome = bp.res_flags[3];
            3'b101:  outcome = bp.res_flags[4];
            default: type_ok = 1'b0;
        endcase
    end

    assign res_ok     = bp.res_valid & type_ok;
    assign mispredict = res_ok & (outcome != bp.res_pred);

    always_comb begin
        ctr_cur = tbl_q[bp.res_idx];
        ctr_nxt = ctr_cur;
        if (outcome) begin
            if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) tbl_q[i] <= 2'b01;
        end else if (res_ok) begin
            tbl_q[bp.res_idx] <= ctr_nxt;
        end
    end

    // redirect_taken holds its value between mispredicts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_q       <= 1'b0;
            redirect_taken_q <= 1'b0;
        end else begin
            redirect_q <= mispredict;
            if (mispredict) redirect_taken_q <= outcome;
        end
    end

    // No bypass: a same-cycle resolve to pred_idx is visible only after the edge.
    assign bp.pred_taken     = tbl_q[bp.pred_idx][1];
    assign bp.redirect       = redirect_q;
    assign bp.redirect_taken = redirect_taken_q;

`ifdef BP_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mp_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q <= 32'd0;
            mp_cnt_q <= 32'd0;
        end else begin
            if (res_ok)     br_cnt_q <= br_cnt_q + 32'd1;
            if (mispredict) mp_cnt_q <= mp_cnt_q + 32'd1;
        end
    end

    assign bp.br_cnt = br_cnt_q;
    assign bp.mp_cnt = mp_cnt_q;
`else
    assign bp.br_cnt = 32'd0;
    assign bp.mp_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_branch_predict.sv
// Directed bench for branch_predict with a scoreboard queue.
// Each driven cycle pushes the expected outputs for the falling edge of that cycle;
// the monitor pops and compares on every falling edge while expectations are pending.
module tb_branch_predict;
    localparam int unsigned IDX_W = 6;
`ifdef BP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst;

    branch_predict_if #(.IDX_W(IDX_W)) bp ();

    branch_predict #(.IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          row;
        logic        pt;
        logic        rd;
        logic        rdt;
        logic [31:0] br;
        logic [31:0] mp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   row_n    = 0;

    function automatic void chk(string nm, int row, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=0x%0h expected=0x%0h", nm, row, act, exp);
        end
    endfunction

    // Monitor: compares the presented outputs against the oldest pending expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pred_taken",     e.row, {31'd0, bp.pred_taken},     {31'd0, e.pt});
            chk("redirect",       e.row, {31'd0, bp.redirect},       {31'd0, e.rd});
            chk("redirect_taken", e.row, {31'd0, bp.redirect_taken}, {31'd0, e.rdt});
            chk("br_cnt",         e.row, bp.br_cnt,                  e.br);
            chk("mp_cnt",         e.row, bp.mp_cnt,                  e.mp);
        end
    end

    // Drive one cycle just after the rising edge; expectations describe this cycle's
    // falling-edge view (table/redirect state after the edge that just happened).
    task automatic cyc(input logic r, input logic [IDX_W-1:0] pidx, input logic rv,
                       input logic [IDX_W-1:0] ridx, input logic [2:0] rtype,
                       input logic [4:0] rflags, input logic rpred,
                       input logic pt, input logic rd, input logic rdt,
                       input logic [31:0] br, input logic [31:0] mp, input bit frc);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        bp.pred_idx  = pidx;
        bp.res_valid = rv;
        bp.res_idx   = ridx;
        bp.res_type  = rtype;
        bp.res_flags = rflags;
        bp.res_pred  = rpred;
`ifdef BP_STATS_EN
        if (frc) begin
            force dut.br_cnt_q = 32'hFFFF_FFFF;
            force dut.mp_cnt_q = 32'hFFFF_FFFF;
            #1;
            release dut.br_cnt_q;
            release dut.mp_cnt_q;
        end
`else
        if (frc) #1;
`endif
        e.row = row_n;
        e.pt  = pt;
        e.rd  = rd;
        e.rdt = rdt;
        e.br  = STATS ? br : 32'd0;
        e.mp  = STATS ? mp : 32'd0;
        exp_q.push_back(e);
        row_n++;
    endtask

    initial begin
        rst          = 1'b1;
        bp.pred_idx  = '0;
        bp.res_valid = 1'b0;
        bp.res_idx   = '0;
        bp.res_type  = 3'b000;
        bp.res_flags = 5'b00000;
        bp.res_pred  = 1'b0;

        //  rst pidx rv ridx type     flags     pred  pt rd rdt br  mp  frc
        // Reset, and a resolve held under reset is discarded.
        cyc(1, 5,  0, 0,  3'b000, 5'b00000, 0,  0, 0, 0, 0,  0,  0);
        cyc(1, 5,  1, 5,  3'b000, 5'b00001, 0,  0, 0, 0, 0,  0,  0);
        cyc(0, 5,  0, 0,  3'b000, 5'b00000, 0,  0, 0, 0, 0,  0,  0);
        // BEQ taken at idx5, predicted NT: redirect to target, counter 01->10.
        cyc(0, 5,  1, 5,  3'b000, 5'b00001, 0,  0, 0, 0, 0,  0,  0);
        cyc(0, 5,  0, 0,  3'b000, 5'b00000, 0,  1, 1, 1, 1,  1,  0);
        cyc(0, 5,  0, 0,  3'b000, 5'b00000, 0,  1, 0, 1, 1,  1,  0);
        // Four taken BGTZ at idx3: 01->10->11->11, redirect on first only.
        cyc(0, 3,  1, 3,  3'b011, 5'b00100, 0,  0, 0, 1, 1,  1,  0);
        cyc(0, 3,  1, 3,  3'b011, 5'b00100, 1,  1, 1, 1, 2,  2,  0);
        cyc(0, 3,  1, 3,  3'b011, 5'b00100, 1,  1, 0, 1, 3,  2,  0);
        cyc(0, 3,  1, 3,  3'b011, 5'b00100, 1,  1, 0, 1, 4,  2,  0);
        cyc(0, 3,  0, 0,  3'b000, 5'b00000, 0,  1, 0, 1, 5,  2,  0);
        // BEQ not taken: 11->10 (still predicts taken), redirect to fall-through.
        cyc(0, 3,  1, 3,  3'b000, 5'b00000, 1,  1, 0, 1, 5,  2,  0);
        cyc(0, 3,  0, 0,  3'b000, 5'b00000, 0,  1, 1, 0, 6,  3,  0);
        cyc(0, 3,  0, 0,  3'b000, 5'b00000, 0,  1, 0, 0, 6,  3,  0);
        // Same-index lookup during resolve shows the pre-update value.
        cyc(0, 7,  1, 7,  3'b001, 5'b00000, 0,  0, 0, 0, 6,  3,  0);
        cyc(0, 7,  0, 0,  3'b000, 5'b00000, 0,  1, 1, 1, 7,  4,  0);
        // BLEZ taken, BLTZ not taken (lez set, ltz clear), BGEZ taken.
        cyc(0, 7,  1, 7,  3'b100, 5'b01000, 1,  1, 0, 1, 7,  4,  0);
        cyc(0, 7,  1, 7,  3'b101, 5'b01000, 1,  1, 0, 1, 8,  4,  0);
        cyc(0, 7,  1, 7,  3'b010, 5'b00010, 1,  1, 1, 0, 9,  5,  0);
        cyc(0, 7,  0, 0,  3'b000, 5'b00000, 0,  1, 0, 0, 10, 5,  0);
        // Invalid types and res_valid=0 with live-looking fields are no-ops.
        cyc(0, 9,  1, 9,  3'b111, 5'b11111, 0,  0, 0, 0, 10, 5,  0);
        cyc(0, 9,  1, 9,  3'b110, 5'b11111, 0,  0, 0, 0, 10, 5,  0);
        cyc(0, 9,  0, 0,  3'b000, 5'b00000, 0,  0, 0, 0, 10, 5,  0);
        cyc(0, 9,  0, 9,  3'b000, 5'b11111, 0,  0, 0, 0, 10, 5,  0);
        cyc(0, 9,  0, 0,  3'b000, 5'b00000, 0,  0, 0, 0, 10, 5,  0);
        // Reset asserted during a redirect pulse: pulse and state cleared at once.
        cyc(0, 20, 1, 20, 3'b000, 5'b00001, 0,  0, 0, 0, 10, 5,  0);
        cyc(1, 3,  0, 0,  3'b000, 5'b00000, 0,  0, 0, 0, 0,  0,  0);
        cyc(1, 7,  0, 0,  3'b000, 5'b00000, 0,  0, 0, 0, 0,  0,  0);
        // First edge after reset release processes normally; counter back at 01.
        cyc(0, 7,  1, 7,  3'b000, 5'b00001, 0,  0, 0, 0, 0,  0,  0);
        cyc(0, 7,  0, 0,  3'b000, 5'b00000, 0,  1, 1, 1, 1,  1,  0);
        cyc(0, 7,  0, 0,  3'b000, 5'b00000, 0,  1, 0, 1, 1,  1,  0);
        // Statistics wrap from all-ones (counters forced when stats are built).
        cyc(0, 40, 1, 40, 3'b000, 5'b00001, 1,  0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        cyc(0, 40, 1, 40, 3'b000, 5'b00000, 1,  1, 0, 1, 0,  32'hFFFF_FFFF, 0);
        cyc(0, 40, 0, 0,  3'b000, 5'b00000, 0,  0, 1, 0, 1,  0,  0);

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predict.md
BRANCH_PREDICT -- requirements
Module: branch_predict

Interface
REQ-001 SHALL have parameter IDX_W, default 6, meaning table index width (2^IDX_W entries).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pred_idx  input  IDX_W  fetch-side index (PC[IDX_W+1:2]).
REQ-005 SHALL have port pred_taken  output  1  combinational prediction = MSB of indexed counter.
REQ-006 SHALL have port res_valid  input  1  decode-side branch resolution strobe.
REQ-007 SHALL have port res_idx  input  IDX_W  index of the branch being resolved.
REQ-008 SHALL have port res_type  input  3  000 BEQ, 001 BNE, 010 BGEZ, 011 BGTZ, 100 BLEZ, 101 BLTZ; 110/111 invalid.
REQ-009 SHALL have port res_flags  input  5  comparator flags {ltz,lez,gtz,gez,eq}, bit0 = eq.
REQ-010 SHALL have port res_pred  input  1  prediction that fetch used for this branch.
REQ-011 SHALL have port redirect  output  1  registered one-cycle mispredict pulse.
REQ-012 SHALL have port redirect_taken  output  1  registered; 1 = refetch at target, 0 = refetch fall-through.
REQ-013 SHALL have ports br_cnt, mp_cnt  output  32 each  branch / mispredict counters.

Function
REQ-014 SHALL hold 2^IDX_W 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-015 SHALL compute outcome combinationally: BEQ=eq, BNE=~eq, BGEZ=gez, BGTZ=gtz, BLEZ=lez, BLTZ=ltz.
REQ-016 SHALL treat res_valid with res_type 110/111 as no-op: no table write, no redirect, no count.
REQ-017 SHALL, on valid resolve, update counter at res_idx on the same edge: taken -> +1 saturating at 11; not taken -> -1 saturating at 00.
REQ-018 SHALL assert redirect for exactly the cycle after a valid resolve whose outcome != res_pred, with redirect_taken = outcome.
REQ-019 SHALL drive redirect=0 and hold redirect_taken at its last value in every other cycle.
REQ-020 SHALL, when pred_idx == res_idx in a resolve cycle, return the pre-update counter on pred_taken (no bypass).
REQ-021 SHALL accept back-to-back resolves every cycle, including to the same index (each applies to the prior edge's value).
REQ-022 SHALL ignore res_type, res_flags, res_idx and res_pred while res_valid=0.

Reset
REQ-023 SHALL, while rst=1, force all counters to 01, redirect=0, redirect_taken=0, br_cnt=0, mp_cnt=0, independent of clk.
REQ-024 SHALL discard any resolve present in the cycle rst deasserts only if rst is still high at that edge; the first edge with rst=0 processes inputs normally.

Configuration
REQ-025 SHALL, with BP_STATS_EN defined, increment br_cnt per valid resolve and mp_cnt per mispredict, both wrapping 0xFFFFFFFF -> 0.
REQ-026 SHALL, without BP_STATS_EN, omit counter registers and drive br_cnt and mp_cnt to constant 0.

Verification
REQ-027 SHALL cover: reset, then pred_idx=5 -> pred_taken=0; resolve idx5 BEQ eq=1 res_pred=0 -> next cycle redirect=1, redirect_taken=1, idx5 counter=10, pred_taken=1.
REQ-028 SHALL cover: four consecutive taken BGTZ resolves at idx3 -> counter 01->10->11->11 (saturation), redirect only on first.
REQ-029 SHALL cover: resolve idx7 with pred_idx=7 in same cycle -> pred_taken shows old value that cycle, new value next cycle.
REQ-030 SHALL cover: res_type=111 res_valid=1 -> no redirect, counters unchanged, br_cnt unchanged.
REQ-031 SHALL cover: rst asserted mid-redirect pulse -> redirect drops immediately, all counters read 01.
REQ-032 SHALL cover (BP_STATS_EN): br_cnt preloaded by force to 0xFFFFFFFF, one valid resolve -> br_cnt=0; without macro br_cnt=mp_cnt=0 throughout.
